sram_ctrl: RTL and testbench
============================

# sram_ctrl

Physical-memory access controller directly downstream of the TLB stage. It takes the translated physical address and access request, plus the TLB exception flags, and runs a multi-cycle read or write on an asynchronous 32-bit external SRAM. It stalls the pipeline until the access completes and returns read data with a one-cycle acknowledge. Requests that arrive with a TLB exception flag set are dropped without touching the SRAM.

## Interface
- WAIT_CYCLES, 2: cycles the SRAM strobes stay active per access; legal range ≥1.
- SRAM_AW, 20: SRAM word-address width.
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- req_i  in  1  access request (chip enable from the memory stage).
- we_i  in  1  1 = write, 0 = read.
- addr_i  in  32  physical byte address (translated `tlb_addr`).
- sel_i  in  4  byte enables, active-high; bit 3 = data[31:24].
- data_i  in  32  write data.
- tlbm_i / tlbl_i / tlbs_i  in  1 each  TLB exception flags for the current request.
- data_o  out  32  read data; registered; valid while ack_o=1.
- ack_o  out  1  access complete; one-cycle pulse.
- err_o  out  1  address out of range; pulses together with ack_o.
- stall_o  out  1  pipeline stall; combinational.
- sram_addr_o  out  SRAM_AW  SRAM word address.
- sram_dq_o  out  32  SRAM write data.
- sram_dq_i  in  32  SRAM read data.
- sram_dq_oe  out  1  write-data output enable; the tristate buffer lives at top level.
- sram_ce_n, sram_oe_n, sram_we_n  out  1 each  SRAM strobes, active-low.
- sram_be_n  out  4  SRAM byte enables, active-low.

## Operation
- **Request start.** A request starts only in IDLE, and only when req_i=1 and all TLB flags are 0.
- **Latching.** At start, addr, we, sel and data are latched. The inputs are ignored until the controller returns to IDLE.
- **SRAM address.** sram_addr_o = addr_i[SRAM_AW+1:2].
- **Range check.** If addr_i[31:SRAM_AW+2] ≠ 0, the request is out of range:
  - go to DONE directly, with no strobe activity;
  - err_o=1 and data_o=0 in DONE.
- **States.** IDLE → ACCESS → (write only) HOLD → DONE → IDLE.
- **ACCESS**
  - sram_ce_n=0 and sram_be_n=~sel.
  - Read: sram_oe_n=0.
  - Write: sram_we_n=0 and sram_dq_oe=1.
  - A counter runs 0..WAIT_CYCLES-1 and the state exits when it reaches WAIT_CYCLES-1.
  - Read data is captured into data_o on the exiting edge.
- **HOLD** (write only): sram_we_n=1; ce_n, be_n, address, dq and dq_oe are held for one cycle (data-hold margin).
- **DONE**
  - All strobes are inactive (ce_n=oe_n=we_n=1, be_n=4'hF, dq_oe=0).
  - ack_o=1.
  - Next state is always IDLE; there is no back-to-back start from DONE.
- **stall_o**
  - In IDLE: stall_o = req_i & ~(tlbm_i|tlbl_i|tlbs_i).
  - In ACCESS and HOLD: stall_o = 1.
  - In DONE: stall_o = 0.
- **TLB exception.** A TLB exception with req_i=1 in IDLE gives no stall, no ack and no SRAM activity. The exception path is handled upstream.
- **Flags mid-access.** Flag changes during ACCESS/HOLD are ignored.

## Timing
- **Reset values of outputs:**
  - data_o=0, ack_o=0, err_o=0;
  - sram_addr_o=0, sram_dq_o=0, sram_dq_oe=0;
  - sram_ce_n=sram_oe_n=sram_we_n=1, sram_be_n=4'hF;
  - stall_o=0 while rst=1.
- **Read latency.** With req in IDLE at cycle n:
  - ACCESS occupies n+1..n+WAIT_CYCLES;
  - ack_o=1 at cycle n+WAIT_CYCLES+1.
- **Write latency.** ACCESS n+1..n+WAIT_CYCLES, HOLD at n+WAIT_CYCLES+1, ack_o at n+WAIT_CYCLES+2.
- **Out-of-range latency.** ack_o and err_o at cycle n+1.
- **Next request.** If req_i is still 1 in the IDLE cycle after DONE, it is treated as a new access. The pipeline is required to have advanced during DONE.
- **Strobe outputs.** All strobe outputs are registered (glitch-free). They change only on the clk edge.
- **Reset mid-access.** At the next edge: state=IDLE, all strobes inactive, no ack. The aborted write is undefined in SRAM contents.
- **Wrap-around.** No wrap-around: the address is latched once per access.

## Structure
- Shared package holds:
  - the state encoding (IDLE, ACCESS, HOLD, DONE);
  - the SRAM_AW default;
  - the strobe-inactive constants.
- The WAIT_CYCLES counter is width $clog2(WAIT_CYCLES+1).
- Single module; no sub-module is natural, because the counter and FSM are tightly coupled.
- The tristate on sram_dq is kept at top level.

## Test plan
- **Read.** WAIT_CYCLES=2, SRAM preloaded 0x00000010=32'hDEADBEEF; read addr 0x00000010, sel=4'hF.
  - sram_addr_o=20'h4; oe_n low 2 cycles; ack at n+3 with data_o=32'hDEADBEEF.
  - stall_o=1 for n..n+2.
- **Byte write.** Write addr 0x00000020, data 32'h000000AB, sel=4'b0001.
  - be_n=4'b1110; we_n low 2 cycles then high in HOLD with dq_oe still 1; ack at n+4.
  - Read-back of the byte returns 8'hAB.
- **TLB exception.** req_i=1, tlbs_i=1, addr 0x00000040: ce_n stays 1, stall_o=0, no ack.
- **Out of range.** Read addr 0x10000000: no strobes, ack_o=err_o=1 at n+1, data_o=0.
- **Reset mid-access.** rst asserted in the 2nd ACCESS cycle of a write: next edge we_n=ce_n=1, be_n=4'hF, no ack. A following read completes normally.
- **Back-to-back.** req_i held high for two reads with the address changing in the DONE cycle: the second access latches the new address, and the ack pulses are separated by WAIT_CYCLES+2 cycles.

Source files
------------

// File: rtl/sram_ctrl_pkg.sv
// Shared definitions for the SRAM access controller: state encoding,
// default SRAM geometry and the idle (inactive) strobe levels.
package sram_ctrl_pkg;

    localparam int SRAM_AW_DEFAULT = 20;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_HOLD   = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    localparam logic       STROBE_OFF = 1'b1;
    localparam logic [3:0] BE_OFF     = 4'hF;

    // Any byte-address bit above the SRAM word range makes the access illegal.
    function automatic logic addr_out_of_range(input logic [31:0] addr, input int aw);
        return (addr >> (aw + 2)) != 32'd0;
    endfunction

endpackage

// File: rtl/sram_ctrl_if.sv
// Pipeline-side request/response bus between the memory stage and sram_ctrl.
interface sram_ctrl_if;

    logic        req_i;
    logic        we_i;
    logic [31:0] addr_i;
    logic [3:0]  sel_i;
    logic [31:0] data_i;
    logic        tlbm_i;
    logic        tlbl_i;
    logic        tlbs_i;
    logic [31:0] data_o;
    logic        ack_o;
    logic        err_o;
    logic        stall_o;

    modport master (
        output req_i, we_i, addr_i, sel_i, data_i, tlbm_i, tlbl_i, tlbs_i,
        input  data_o, ack_o, err_o, stall_o
    );

    modport slave (
        input  req_i, we_i, addr_i, sel_i, data_i, tlbm_i, tlbl_i, tlbs_i,
        output data_o, ack_o, err_o, stall_o
    );

endinterface

// File: rtl/sram_ctrl.sv
// Multi-cycle read/write controller for an asynchronous 32-bit SRAM that
// stalls the pipeline while an access is in flight; all SRAM pins are registered.
module sram_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int WAIT_CYCLES = 2,
    parameter int SRAM_AW     = SRAM_AW_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    sram_ctrl_if.slave         bus,
    output logic [SRAM_AW-1:0] sram_addr_o,
    output logic [31:0]        sram_dq_o,
    input  logic [31:0]        sram_dq_i,
    output logic               sram_dq_oe,
    output logic               sram_ce_n,
    output logic               sram_oe_n,
    output logic               sram_we_n,
    output logic [3:0]         sram_be_n
);

    localparam int                CNT_W    = $clog2(WAIT_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_we;
    logic [31:0]      r_data;
    logic             r_ack;
    logic             r_err;

    logic w_tlb_exc;
    logic w_start;
    logic w_oor;
    logic w_cnt_last;
    logic w_stall;

    assign w_tlb_exc  = bus.tlbm_i | bus.tlbl_i | bus.tlbs_i;
    assign w_start    = (r_state == ST_IDLE) && bus.req_i && !w_tlb_exc;
    assign w_oor      = addr_out_of_range(bus.addr_i, SRAM_AW);
    assign w_cnt_last = (r_cnt == CNT_LAST);

    // Strobes are updated on the same edge that moves the FSM, so each pin
    // already shows the level belonging to the state being entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_we        <= 1'b0;
            r_data      <= '0;
            r_ack       <= 1'b0;
            r_err       <= 1'b0;
            sram_addr_o <= '0;
            sram_dq_o   <= '0;
            sram_dq_oe  <= 1'b0;
            sram_ce_n   <= STROBE_OFF;
            sram_oe_n   <= STROBE_OFF;
            sram_we_n   <= STROBE_OFF;
            sram_be_n   <= BE_OFF;
        end else begin
            r_ack <= 1'b0;
            r_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_we  <= bus.we_i;
                        r_cnt <= '0;
                        if (w_oor) begin
                            r_state <= ST_DONE;
                            r_ack   <= 1'b1;
                            r_err   <= 1'b1;
                            r_data  <= '0;
                        end else begin
                            r_state     <= ST_ACCESS;
                            sram_addr_o <= bus.addr_i[SRAM_AW+1:2];
                            sram_dq_o   <= bus.data_i;
                            sram_ce_n   <= 1'b0;
                            sram_be_n   <= ~bus.sel_i;
                            sram_oe_n   <= bus.we_i;
                            sram_we_n   <= ~bus.we_i;
                            sram_dq_oe  <= bus.we_i;
                        end
                    end
                end
                ST_ACCESS: begin
                    if (w_cnt_last) begin
                        if (r_we) begin
                            r_state   <= ST_HOLD;
                            sram_we_n <= STROBE_OFF;
                        end else begin
                            r_state    <= ST_DONE;
                            r_ack      <= 1'b1;
                            r_data     <= sram_dq_i;
                            sram_ce_n  <= STROBE_OFF;
                            sram_oe_n  <= STROBE_OFF;
                            sram_be_n  <= BE_OFF;
                            sram_dq_oe <= 1'b0;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_HOLD: begin
                    r_state    <= ST_DONE;
                    r_ack      <= 1'b1;
                    sram_ce_n  <= STROBE_OFF;
                    sram_we_n  <= STROBE_OFF;
                    sram_be_n  <= BE_OFF;
                    sram_dq_oe <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Stall is combinational so the pipeline freezes in the request cycle itself.
    always_comb begin
        w_stall = 1'b0;
        case (r_state)
            ST_IDLE:           w_stall = bus.req_i & ~w_tlb_exc;
            ST_ACCESS, ST_HOLD: w_stall = 1'b1;
            default:           w_stall = 1'b0;
        endcase
    end

    assign bus.stall_o = w_stall & ~rst;
    assign bus.data_o  = r_data;
    assign bus.ack_o   = r_ack;
    assign bus.err_o   = r_err;

endmodule

// File: tb/tb_sram_ctrl.sv
// Directed self-checking bench for sram_ctrl with a behavioural async SRAM
// model (byte-enabled writes, combinational reads).
module tb_sram_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;

    sram_ctrl_if bus();

    logic [19:0] sram_addr_o;
    logic [31:0] sram_dq_o;
    logic [31:0] sram_dq_i;
    logic        sram_dq_oe;
    logic        sram_ce_n;
    logic        sram_oe_n;
    logic        sram_we_n;
    logic [3:0]  sram_be_n;

    logic [31:0] mem [0:255];
    logic [7:0]  memIdx;
    logic        preEn;
    logic [7:0]  preIdx;
    logic [31:0] preData;

    int testsRun    = 0;
    int testsFailed = 0;

    sram_ctrl #(.WAIT_CYCLES(2), .SRAM_AW(20)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .sram_addr_o (sram_addr_o),
        .sram_dq_o   (sram_dq_o),
        .sram_dq_i   (sram_dq_i),
        .sram_dq_oe  (sram_dq_oe),
        .sram_ce_n   (sram_ce_n),
        .sram_oe_n   (sram_oe_n),
        .sram_we_n   (sram_we_n),
        .sram_be_n   (sram_be_n)
    );

    always #5 clk = ~clk;

    // Behavioural SRAM: writes land on each clock edge seen with ce/we low.
    assign memIdx    = 8'(sram_addr_o);
    assign sram_dq_i = (!sram_ce_n && !sram_oe_n) ? mem[memIdx] : 32'h0;

    always @(posedge clk) begin
        if (preEn) begin
            mem[preIdx] <= preData;
        end else if (!sram_ce_n && !sram_we_n && sram_dq_oe) begin
            for (int b = 0; b < 4; b++) begin
                if (!sram_be_n[b]) mem[memIdx][8*b +: 8] <= sram_dq_o[8*b +: 8];
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.req_i = 1'b1;
        preEn = 1'b1; preIdx = 8'd4; preData = 32'hDEADBEEF;
        tick();
        preIdx = 8'd8; preData = 32'h11223344;
        tick();
        preEn = 1'b0;
        testsRun++; if (bus.stall_o !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_stall: got %b expected 0", bus.stall_o); end
        testsRun++; if (bus.ack_o !== 1'b0 || bus.err_o !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_ack_err: got %b%b expected 00", bus.ack_o, bus.err_o); end
        testsRun++; if (bus.data_o !== 32'h0) begin testsFailed++; $display("[TB] FAIL reset_data: got %h expected 0", bus.data_o); end
        testsRun++; if (sram_addr_o !== 20'h0 || sram_dq_o !== 32'h0 || sram_dq_oe !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_addr_dq: got %h %h %b expected 0 0 0", sram_addr_o, sram_dq_o, sram_dq_oe); end
        testsRun++; if ({sram_ce_n, sram_oe_n, sram_we_n, sram_be_n} !== 7'h7F) begin testsFailed++; $display("[TB] FAIL reset_strobes: got %b expected 1111111", {sram_ce_n, sram_oe_n, sram_we_n, sram_be_n}); end
        bus.req_i = 1'b0;
        rst = 1'b0;
        tick();
        testsRun++; if (sram_ce_n !== 1'b1 || bus.stall_o !== 1'b0) begin testsFailed++; $display("[TB] FAIL idle_after_reset: got ce_n=%b stall=%b expected 1 0", sram_ce_n, bus.stall_o); end
    endtask

    task automatic test_read();
        bus.req_i = 1'b1; bus.we_i = 1'b0; bus.addr_i = 32'h10; bus.sel_i = 4'hF;
        #1;
        testsRun++; if (bus.stall_o !== 1'b1) begin testsFailed++; $display("[TB] FAIL read_stall_n: got %b expected 1", bus.stall_o); end
        tick();
        bus.req_i = 1'b0;
        testsRun++; if (sram_addr_o !== 20'h4) begin testsFailed++; $display("[TB] FAIL read_addr: got %h expected 00004", sram_addr_o); end
        testsRun++; if ({sram_ce_n, sram_oe_n, sram_we_n, sram_be_n} !== 7'b0010000) begin testsFailed++; $display("[TB] FAIL read_strobes_n1: got %b expected 0010000", {sram_ce_n, sram_oe_n, sram_we_n, sram_be_n}); end
        testsRun++; if (bus.stall_o !== 1'b1 || bus.ack_o !== 1'b0) begin testsFailed++; $display("[TB] FAIL read_n1_stall_ack: got %b%b expected 10", bus.stall_o, bus.ack_o); end
        tick();
        testsRun++; if (sram_oe_n !== 1'b0 || bus.stall_o !== 1'b1 || bus.ack_o !== 1'b0) begin testsFailed++; $display("[TB] FAIL read_n2: got oe_n=%b stall=%b ack=%b expected 0 1 0", sram_oe_n, bus.stall_o, bus.ack_o); end
        tick();
        testsRun++; if (bus.ack_o !== 1'b1 || bus.err_o !== 1'b0) begin testsFailed++; $display("[TB] FAIL read_ack: got ack=%b err=%b expected 1 0", bus.ack_o, bus.err_o); end
        testsRun++; if (bus.data_o !== 32'hDEADBEEF) begin testsFailed++; $display("[TB] FAIL read_data: got %h expected deadbeef", bus.data_o); end
        testsRun++; if (sram_ce_n !== 1'b1 || sram_oe_n !== 1'b1 || bus.stall_o !== 1'b0) begin testsFailed++; $display("[TB] FAIL read_done_idle: got ce_n=%b oe_n=%b stall=%b expected 1 1 0", sram_ce_n, sram_oe_n, bus.stall_o); end
        tick();
        testsRun++; if (bus.ack_o !== 1'b0) begin testsFailed++; $display("[TB] FAIL read_ack_pulse: got %b expected 0", bus.ack_o); end
    endtask

    task automatic test_byte_write();
        bus.req_i = 1'b1; bus.we_i = 1'b1; bus.addr_i = 32'h20; bus.sel_i = 4'b0001; bus.data_i = 32'h000000AB;
        tick();
        bus.req_i = 1'b0; bus.data_i = 32'hFFFFFFFF;
        testsRun++; if ({sram_ce_n, sram_oe_n, sram_we_n, sram_be_n, sram_dq_oe} !== 8'b01011101) begin testsFailed++; $display("[TB] FAIL write_strobes_n1: got %b expected 01011101", {sram_ce_n, sram_oe_n, sram_we_n, sram_be_n, sram_dq_oe}); end
        testsRun++; if (sram_dq_o !== 32'h000000AB || sram_addr_o !== 20'h8) begin testsFailed++; $display("[TB] FAIL write_dq_addr: got %h %h expected 000000ab 00008", sram_dq_o, sram_addr_o); end
        tick();
        testsRun++; if (sram_we_n !== 1'b0 || bus.ack_o !== 1'b0) begin testsFailed++; $display("[TB] FAIL write_n2: got we_n=%b ack=%b expected 0 0", sram_we_n, bus.ack_o); end
        tick();
        testsRun++; if ({sram_ce_n, sram_we_n, sram_be_n, sram_dq_oe} !== 7'b0111101 || sram_dq_o !== 32'h000000AB) begin testsFailed++; $display("[TB] FAIL write_hold: got %b dq=%h expected 0111101 dq=000000ab", {sram_ce_n, sram_we_n, sram_be_n, sram_dq_oe}, sram_dq_o); end
        testsRun++; if (bus.stall_o !== 1'b1 || bus.ack_o !== 1'b0) begin testsFailed++; $display("[TB] FAIL write_hold_stall_ack: got %b%b expected 10", bus.stall_o, bus.ack_o); end
        tick();
        testsRun++; if (bus.ack_o !== 1'b1 || sram_ce_n !== 1'b1 || sram_dq_oe !== 1'b0 || sram_be_n !== 4'hF) begin testsFailed++; $display("[TB] FAIL write_done: got ack=%b ce_n=%b oe=%b be_n=%b expected 1 1 0 1111", bus.ack_o, sram_ce_n, sram_dq_oe, sram_be_n); end
        tick();
        bus.req_i = 1'b1; bus.we_i = 1'b0; bus.addr_i = 32'h20; bus.sel_i = 4'hF;
        tick();
        bus.req_i = 1'b0;
        tick();
        tick();
        testsRun++; if (bus.ack_o !== 1'b1 || bus.data_o[7:0] !== 8'hAB) begin testsFailed++; $display("[TB] FAIL write_readback_byte: got ack=%b byte=%h expected 1 ab", bus.ack_o, bus.data_o[7:0]); end
        testsRun++; if (bus.data_o !== 32'h112233AB) begin testsFailed++; $display("[TB] FAIL write_readback_word: got %h expected 112233ab", bus.data_o); end
        tick();
    endtask

    task automatic test_tlb_exception();
        bus.req_i = 1'b1; bus.we_i = 1'b0; bus.addr_i = 32'h40; bus.tlbs_i = 1'b1;
        #1;
        testsRun++; if (bus.stall_o !== 1'b0) begin testsFailed++; $display("[TB] FAIL tlb_stall: got %b expected 0", bus.stall_o); end
        for (int c = 0; c < 3; c++) begin
            tick();
            testsRun++; if (sram_ce_n !== 1'b1 || bus.ack_o !== 1'b0 || bus.stall_o !== 1'b0) begin testsFailed++; $display("[TB] FAIL tlb_idle_c%0d: got ce_n=%b ack=%b stall=%b expected 1 0 0", c, sram_ce_n, bus.ack_o, bus.stall_o); end
        end
        bus.req_i = 1'b0; bus.tlbs_i = 1'b0;
        tick();
    endtask

    task automatic test_out_of_range();
        bus.req_i = 1'b1; bus.we_i = 1'b0; bus.addr_i = 32'h10000000; bus.sel_i = 4'hF;
        tick();
        bus.req_i = 1'b0;
        testsRun++; if (bus.ack_o !== 1'b1 || bus.err_o !== 1'b1) begin testsFailed++; $display("[TB] FAIL oor_ack_err: got %b%b expected 11", bus.ack_o, bus.err_o); end
        testsRun++; if (bus.data_o !== 32'h0) begin testsFailed++; $display("[TB] FAIL oor_data: got %h expected 0", bus.data_o); end
        testsRun++; if ({sram_ce_n, sram_oe_n, sram_we_n, sram_be_n} !== 7'h7F) begin testsFailed++; $display("[TB] FAIL oor_strobes: got %b expected 1111111", {sram_ce_n, sram_oe_n, sram_we_n, sram_be_n}); end
        tick();
        testsRun++; if (bus.ack_o !== 1'b0 || bus.err_o !== 1'b0) begin testsFailed++; $display("[TB] FAIL oor_pulse: got %b%b expected 00", bus.ack_o, bus.err_o); end
    endtask

    task automatic test_reset_mid_access();
        bus.req_i = 1'b1; bus.we_i = 1'b1; bus.addr_i = 32'h40; bus.sel_i = 4'hF; bus.data_i = 32'h55555555;
        tick();
        bus.req_i = 1'b0;
        tick();
        testsRun++; if (sram_we_n !== 1'b0) begin testsFailed++; $display("[TB] FAIL rma_second_access: got we_n=%b expected 0", sram_we_n); end
        rst = 1'b1;
        tick();
        testsRun++; if ({sram_ce_n, sram_we_n, sram_be_n, sram_dq_oe} !== 7'b1111110) begin testsFailed++; $display("[TB] FAIL rma_strobes: got %b expected 1111110", {sram_ce_n, sram_we_n, sram_be_n, sram_dq_oe}); end
        testsRun++; if (bus.ack_o !== 1'b0 || bus.stall_o !== 1'b0) begin testsFailed++; $display("[TB] FAIL rma_ack_stall: got %b%b expected 00", bus.ack_o, bus.stall_o); end
        rst = 1'b0;
        tick();
        testsRun++; if (bus.ack_o !== 1'b0 || sram_ce_n !== 1'b1) begin testsFailed++; $display("[TB] FAIL rma_after: got ack=%b ce_n=%b expected 0 1", bus.ack_o, sram_ce_n); end
        bus.req_i = 1'b1; bus.we_i = 1'b0; bus.addr_i = 32'h10;
        tick();
        bus.req_i = 1'b0;
        tick();
        tick();
        testsRun++; if (bus.ack_o !== 1'b1 || bus.data_o !== 32'hDEADBEEF) begin testsFailed++; $display("[TB] FAIL rma_followup_read: got ack=%b data=%h expected 1 deadbeef", bus.ack_o, bus.data_o); end
        tick();
    endtask

    task automatic test_back_to_back();
        int          ackCyc [0:1];
        int          nAck = 0;
        logic [31:0] d0 = 32'h0;
        logic [31:0] d1 = 32'h0;
        logic [19:0] secondAddr = 20'hFFFFF;
        ackCyc[0] = 0; ackCyc[1] = 0;
        bus.req_i = 1'b1; bus.we_i = 1'b0; bus.addr_i = 32'h10; bus.sel_i = 4'hF;
        for (int c = 1; c <= 30 && nAck < 2; c++) begin
            tick();
            if (nAck == 1 && !sram_ce_n) secondAddr = sram_addr_o;
            if (bus.ack_o === 1'b1) begin
                ackCyc[nAck] = c;
                if (nAck == 0) begin
                    d0 = bus.data_o;
                    bus.addr_i = 32'h20;
                end else begin
                    d1 = bus.data_o;
                    bus.req_i = 1'b0;
                end
                nAck++;
            end
        end
        bus.req_i = 1'b0;
        testsRun++; if (nAck != 2) begin testsFailed++; $display("[TB] FAIL b2b_timeout: got %0d acks expected 2", nAck); end
        testsRun++; if (ackCyc[0] != 3) begin testsFailed++; $display("[TB] FAIL b2b_first_latency: got %0d expected 3", ackCyc[0]); end
        testsRun++; if (ackCyc[1] - ackCyc[0] != 4) begin testsFailed++; $display("[TB] FAIL b2b_gap: got %0d expected 4", ackCyc[1] - ackCyc[0]); end
        testsRun++; if (d0 !== 32'hDEADBEEF || d1 !== 32'h112233AB) begin testsFailed++; $display("[TB] FAIL b2b_data: got %h %h expected deadbeef 112233ab", d0, d1); end
        testsRun++; if (secondAddr !== 20'h8) begin testsFailed++; $display("[TB] FAIL b2b_second_addr: got %h expected 00008", secondAddr); end
        tick();
    endtask

    initial begin
        bus.req_i = 1'b0; bus.we_i = 1'b0; bus.addr_i = 32'h10; bus.sel_i = 4'hF; bus.data_i = 32'h0;
        bus.tlbm_i = 1'b0; bus.tlbl_i = 1'b0; bus.tlbs_i = 1'b0;
        preEn = 1'b0; preIdx = 8'd0; preData = 32'h0;
        test_reset();
        test_read();
        test_byte_write();
        test_tlb_exception();
        test_out_of_range();
        test_reset_mid_access();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
